// File: rtl/rand_matrix_pkg.sv
// rand_matrix_stream shared definitions: FSM encoding,
// default LFSR seeds and feedback tap masks.
package rand_matrix_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GEN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [31:0] DEF_SEED1 = 32'hACE1_ACE1;
    localparam logic [31:0] DEF_SEED2 = 32'h1234_5678;

    // A taps 31,21,1,0 ; B taps 31,27,15,0
    localparam logic [31:0] TAPS_A = 32'h8020_0003;
    localparam logic [31:0] TAPS_B = 32'h8800_8001;

endpackage

// File: rtl/rand_matrix_stream_lfsr32.sv
// Free-running 32-bit Fibonacci LFSR with seed load.
// Ports: clk, rst_n, load, load_val[31:0], q = state[LO +: W].
module lfsr32
    import rand_matrix_pkg::*;
#(
    parameter logic [31:0] TAPS = TAPS_A,
    parameter logic [31:0] SEED = DEF_SEED1,
    parameter int          W    = 8,
    parameter int          LO   = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [31:0]   load_val,
    output logic [W-1:0]  q
);

    logic [31:0] s;

    // An all-zero state would lock up, so it falls back to SEED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s <= SEED;
        end else if (load) begin
            s <= (load_val == '0) ? SEED : load_val;
        end else begin
            s <= {s[30:0], ^(s & TAPS)};
        end
    end

    assign q = s[LO +: W];

endmodule

// File: rtl/rand_matrix_stream.sv
// Streams count matrices of dim_m x dim_n random elements in [elem_min, elem_max].
// Ports: start/abort/config/seed in; out_* valid/ready stream; busy, done, err status.
module rand_matrix_stream
    import rand_matrix_pkg::*;
#(
    parameter int          DATA_W = 8,
    parameter int          DIM_W  = 3,
    parameter int          CNT_W  = 4,
    parameter logic [31:0] SEED1  = DEF_SEED1,
    parameter logic [31:0] SEED2  = DEF_SEED2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DIM_W-1:0]  dim_m,
    input  logic [DIM_W-1:0]  dim_n,
    input  logic [CNT_W-1:0]  count,
    input  logic [DATA_W-1:0] elem_min,
    input  logic [DATA_W-1:0] elem_max,
    input  logic              signed_mode,
    input  logic              seed_load,
    input  logic [31:0]       seed_val,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DIM_W-1:0]  out_row,
    output logic [DIM_W-1:0]  out_col,
    output logic [CNT_W-1:0]  out_mat,
    output logic              out_last_elem,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [DIM_W-1:0]  D1   = DIM_W'(1);
    localparam logic [CNT_W-1:0]  C1   = CNT_W'(1);
    localparam logic [DATA_W:0]   ONE  = (DATA_W+1)'(1);
    localparam logic [DATA_W:0]   FULL = {1'b1, {DATA_W{1'b0}}};

    logic [1:0]        state;
    logic [DIM_W-1:0]  m_q, n_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] min_q, max_q;
    logic              sgn_q;

    logic [DATA_W-1:0] a_lo, b_hi, raw;
    logic              lfsr_load;

    assign lfsr_load = seed_load && (state == ST_IDLE);

    lfsr32 #(.TAPS(TAPS_A), .SEED(SEED1), .W(DATA_W), .LO(0)) u_lfsr_a (
        .clk(clk), .rst_n(rst_n), .load(lfsr_load),
        .load_val(seed_val), .q(a_lo)
    );

    lfsr32 #(.TAPS(TAPS_B), .SEED(SEED2), .W(DATA_W), .LO(DATA_W)) u_lfsr_b (
        .clk(clk), .rst_n(rst_n), .load(lfsr_load),
        .load_val(~seed_val), .q(b_hi)
    );

    assign raw = a_lo ^ b_hi;

    // In IDLE the first element is mapped with the incoming config,
    // since it is loaded on the same edge the config is latched.
    logic [DATA_W-1:0] mn, mx, rem, mapped;
    logic              sg;
    logic [DATA_W:0]   ext_min, ext_max, rng;

    always_comb begin
        mn      = (state == ST_IDLE) ? elem_min    : min_q;
        mx      = (state == ST_IDLE) ? elem_max    : max_q;
        sg      = (state == ST_IDLE) ? signed_mode : sgn_q;
        ext_min = sg ? {mn[DATA_W-1], mn} : {1'b0, mn};
        ext_max = sg ? {mx[DATA_W-1], mx} : {1'b0, mx};
        rng     = ext_max - ext_min + ONE;
        if (rng == '0) rng = ONE;
        rem     = DATA_W'({1'b0, raw} % rng);
        mapped  = (rng == FULL) ? raw : mn + rem;
    end

    logic min_gt_max, cfg_bad;

    always_comb begin
        min_gt_max = signed_mode ? ($signed(elem_min) > $signed(elem_max))
                                 : (elem_min > elem_max);
        cfg_bad    = (dim_m == '0) || (dim_n == '0) ||
                     (count == '0) || min_gt_max;
    end

    logic col_end, row_end, mat_end;

    assign col_end       = (out_col == n_q - D1);
    assign row_end       = (out_row == m_q - D1);
    assign mat_end       = (out_mat == cnt_q - C1);
    assign out_last_elem = out_valid && col_end && row_end;
    assign out_last      = out_last_elem && mat_end;
    assign busy          = (state == ST_GEN);
    assign done          = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            m_q       <= '0;
            n_q       <= '0;
            cnt_q     <= '0;
            min_q     <= '0;
            max_q     <= '0;
            sgn_q     <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
            out_mat   <= '0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (cfg_bad) begin
                            err <= 1'b1;
                        end else begin
                            m_q       <= dim_m;
                            n_q       <= dim_n;
                            cnt_q     <= count;
                            min_q     <= elem_min;
                            max_q     <= elem_max;
                            sgn_q     <= signed_mode;
                            out_row   <= '0;
                            out_col   <= '0;
                            out_mat   <= '0;
                            out_data  <= mapped;
                            out_valid <= 1'b1;
                            state     <= ST_GEN;
                        end
                    end
                end
                ST_GEN: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (out_valid && out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            state     <= ST_DONE;
                        end else begin
                            out_data <= mapped;
                            if (col_end) begin
                                out_col <= '0;
                                if (row_end) begin
                                    out_row <= '0;
                                    out_mat <= out_mat + C1;
                                end else begin
                                    out_row <= out_row + D1;
                                end
                            end else begin
                                out_col <= out_col + D1;
                            end
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rand_matrix_stream.sv
// Directed self-checking bench for rand_matrix_stream.
// A shadow LFSR pair predicts every element value.
module tb_rand_matrix_stream;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, abort = 1'b0;
    logic [2:0] dim_m = '0, dim_n = '0;
    logic [3:0] count = '0;
    logic [7:0] elem_min = '0, elem_max = '0;
    logic       signed_mode = 1'b0, seed_load = 1'b0;
    logic [31:0] seed_val = '0;
    logic [7:0] out_data;
    logic       out_valid, out_ready = 1'b0;
    logic [2:0] out_row, out_col;
    logic [3:0] out_mat;
    logic       out_last_elem, out_last, busy, done, err;

    always #5 clk = ~clk;

    rand_matrix_stream dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .dim_m(dim_m), .dim_n(dim_n), .count(count),
        .elem_min(elem_min), .elem_max(elem_max),
        .signed_mode(signed_mode), .seed_load(seed_load),
        .seed_val(seed_val), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_col(out_col), .out_mat(out_mat),
        .out_last_elem(out_last_elem), .out_last(out_last),
        .busy(busy), .done(done), .err(err)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] ma, mb;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= 32'hACE1ACE1;
            mb <= 32'h12345678;
        end else if (seed_load) begin
            ma <= (seed_val == 0) ? 32'hACE1ACE1 : seed_val;
            mb <= (~seed_val == 0) ? 32'h12345678 : ~seed_val;
        end else begin
            ma <= {ma[30:0], ma[31] ^ ma[21] ^ ma[1] ^ ma[0]};
            mb <= {mb[30:0], mb[31] ^ mb[27] ^ mb[15] ^ mb[0]};
        end
    end

    function automatic logic [7:0] model_map(input logic [7:0] raw,
        input logic [7:0] mn, input logic [7:0] mx, input logic sg);
        int lo, hi, rng;
        lo  = sg ? int'($signed(mn)) : int'(mn);
        hi  = sg ? int'($signed(mx)) : int'(mx);
        rng = hi - lo + 1;
        if (rng == 256) return raw;
        return 8'(lo + int'(raw) % rng);
    endfunction

    logic [7:0] obs_d[64], exp_d[64];
    logic [2:0] obs_r[64], obs_c[64];
    logic [3:0] obs_m[64];
    logic       obs_le[64], obs_l[64];
    int n_xfer, n_done, done_gap, n_err, n_stall_bad, n_valid_after;
    logic end_valid, end_busy, timed_out;

    task automatic seed(input logic [31:0] v);
        seed_load = 1'b1;
        seed_val  = v;
        @(negedge clk);
        seed_load = 1'b0;
    endtask

    // Runs one batch from the current negedge and records every transfer.
    task automatic run_batch(input int m, input int n, input int cnt,
        input logic [7:0] mn, input logic [7:0] mx, input logic sg,
        input int rmode, input int abort_at, input bit poke);
        logic [7:0] exp_cur, hd;
        logic [2:0] hr, hc;
        logic [3:0] hm;
        bit stalled;
        int last_cyc;
        n_xfer = 0; n_done = 0; done_gap = -1; n_err = 0;
        n_stall_bad = 0; n_valid_after = 0;
        dim_m = 3'(m); dim_n = 3'(n); count = 4'(cnt);
        elem_min = mn; elem_max = mx; signed_mode = sg;
        start = 1'b1;
        exp_cur = model_map(ma[7:0] ^ mb[15:8], mn, mx, sg);
        @(negedge clk);
        start = 1'b0;
        stalled = 0;
        last_cyc = -1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (err) n_err++;
            if (done) begin
                n_done++;
                done_gap = cyc - last_cyc;
            end
            if (!busy) break;
            if (stalled && (out_data !== hd || out_row !== hr ||
                            out_col !== hc || out_mat !== hm))
                n_stall_bad++;
            stalled = 0;
            start = (poke && cyc == 2);
            out_ready = (rmode == 0) ? 1'b1 : (cyc % 4 == 0 || cyc % 4 == 3);
            abort = 1'b0;
            if (out_valid && abort_at >= 0 && n_xfer == abort_at) begin
                abort = 1'b1;
            end else if (out_valid && out_ready) begin
                if (n_xfer < 64) begin
                    obs_d[n_xfer] = out_data;
                    obs_r[n_xfer] = out_row;
                    obs_c[n_xfer] = out_col;
                    obs_m[n_xfer] = out_mat;
                    obs_le[n_xfer] = out_last_elem;
                    obs_l[n_xfer] = out_last;
                    exp_d[n_xfer] = exp_cur;
                end
                n_xfer++;
                last_cyc = cyc;
                exp_cur = model_map(ma[7:0] ^ mb[15:8], mn, mx, sg);
            end else if (out_valid) begin
                stalled = 1;
                hd = out_data; hr = out_row; hc = out_col; hm = out_mat;
            end
            @(negedge clk);
        end
        timed_out = busy;
        end_valid = out_valid;
        end_busy  = busy;
        start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) n_done++;
            if (err) n_err++;
            if (out_valid) n_valid_after++;
        end
    endtask

    task automatic test_reset;
        logic [31:0] o;
        repeat (2) @(negedge clk);
        o = {out_valid, busy, done, err, out_last, out_last_elem,
             out_data, out_row, out_col, out_mat};
        checks++;
        if (o !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", o);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        seed(32'h1);
        run_batch(2, 3, 2, 8'd0, 8'd9, 1'b0, 0, -1, 1'b0);
        checks++;
        if (n_xfer !== 12 || timed_out) begin
            errors++;
            $display("FAIL basic_count: got %0d expected 12", n_xfer);
        end
        checks++;
        if (obs_d[0] !== 8'd4 || obs_d[1] !== 8'd2) begin
            errors++;
            $display("FAIL basic_first: got %0d,%0d expected 4,2",
                     obs_d[0], obs_d[1]);
        end
        for (int i = 0; i < 12 && i < n_xfer; i++) begin
            checks++;
            if (obs_d[i] !== exp_d[i] || obs_d[i] > 8'd9) begin
                errors++;
                $display("FAIL basic_data[%0d]: got %0d expected %0d",
                         i, obs_d[i], exp_d[i]);
            end
            checks++;
            if ({obs_m[i], obs_r[i], obs_c[i], obs_le[i], obs_l[i]} !==
                {4'(i / 6), 3'((i % 6) / 3), 3'(i % 3),
                 i == 5 || i == 11, i == 11}) begin
                errors++;
                $display("FAIL basic_idx[%0d]: got m%0d r%0d c%0d le%0d l%0d",
                         i, obs_m[i], obs_r[i], obs_c[i], obs_le[i], obs_l[i]);
            end
        end
        checks++;
        if (n_done !== 1 || done_gap !== 1 || n_err !== 0) begin
            errors++;
            $display("FAIL basic_done: got n=%0d gap=%0d err=%0d expected 1 1 0",
                     n_done, done_gap, n_err);
        end
    endtask

    task automatic test_const_and_full;
        run_batch(2, 2, 1, 8'd5, 8'd5, 1'b0, 0, -1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_d[i] !== 8'd5) begin
                errors++;
                $display("FAIL const[%0d]: got %0d expected 5", i, obs_d[i]);
            end
        end
        run_batch(2, 2, 1, 8'd0, 8'd255, 1'b0, 0, -1, 1'b0);
        checks++;
        if (n_xfer !== 4) begin
            errors++;
            $display("FAIL full_count: got %0d expected 4", n_xfer);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_d[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL full[%0d]: got %0d expected %0d",
                         i, obs_d[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_signed;
        run_batch(3, 3, 1, 8'hFD, 8'h03, 1'b1, 0, -1, 1'b0);
        checks++;
        if (n_xfer !== 9) begin
            errors++;
            $display("FAIL signed_count: got %0d expected 9", n_xfer);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (obs_d[i] !== exp_d[i] || $signed(obs_d[i]) < -3 ||
                $signed(obs_d[i]) > 3) begin
                errors++;
                $display("FAIL signed[%0d]: got %0d expected %0d", i,
                         $signed(obs_d[i]), $signed(exp_d[i]));
            end
        end
    endtask

    task automatic try_reject(input string nm, input int m, input int n,
        input int cnt, input logic [7:0] mn, input logic [7:0] mx,
        input logic sg);
        logic e1, e2, v;
        dim_m = 3'(m); dim_n = 3'(n); count = 4'(cnt);
        elem_min = mn; elem_max = mx; signed_mode = sg;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e1 = err;
        v = out_valid | busy;
        @(negedge clk);
        e2 = err;
        v = v | out_valid | busy;
        checks++;
        if ({e1, e2, v} !== 3'b100) begin
            errors++;
            $display("FAIL reject_%s: got err=%b,%b active=%b expected 1,0,0",
                     nm, e1, e2, v);
        end
    endtask

    task automatic test_backpressure;
        run_batch(3, 3, 1, 8'd10, 8'd40, 1'b0, 1, -1, 1'b0);
        checks++;
        if (n_xfer !== 9 || n_stall_bad !== 0 || n_done !== 1) begin
            errors++;
            $display("FAIL bp_summary: got xfer=%0d stall_bad=%0d done=%0d expected 9 0 1",
                     n_xfer, n_stall_bad, n_done);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if ({obs_d[i], obs_r[i], obs_c[i]} !==
                {exp_d[i], 3'(i / 3), 3'(i % 3)}) begin
                errors++;
                $display("FAIL bp[%0d]: got d%0d r%0d c%0d expected d%0d r%0d c%0d",
                         i, obs_d[i], obs_r[i], obs_c[i], exp_d[i], i / 3, i % 3);
            end
        end
    endtask

    task automatic test_abort;
        logic [7:0] saved[4];
        seed(32'h5A5A_0F0F);
        run_batch(3, 3, 2, 8'd0, 8'd99, 1'b0, 0, 4, 1'b0);
        for (int i = 0; i < 4; i++) saved[i] = obs_d[i];
        checks++;
        if (n_xfer !== 4 || end_valid !== 1'b0 || end_busy !== 1'b0 ||
            n_done !== 0 || n_valid_after !== 0) begin
            errors++;
            $display("FAIL abort: got xfer=%0d valid=%b busy=%b done=%0d expected 4 0 0 0",
                     n_xfer, end_valid, end_busy, n_done);
        end
        seed(32'h5A5A_0F0F);
        run_batch(3, 3, 2, 8'd0, 8'd99, 1'b0, 0, -1, 1'b0);
        checks++;
        if (n_xfer !== 18 || obs_m[0] !== 4'd0 || obs_m[9] !== 4'd1) begin
            errors++;
            $display("FAIL regen: got xfer=%0d m0=%0d m9=%0d expected 18 0 1",
                     n_xfer, obs_m[0], obs_m[9]);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_d[i] !== saved[i] || obs_d[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL regen[%0d]: got %0d expected %0d",
                         i, obs_d[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_start_in_gen;
        run_batch(1, 4, 1, 8'd1, 8'd6, 1'b0, 0, -1, 1'b1);
        checks++;
        if (n_xfer !== 4 || n_err !== 0 || n_done !== 1 ||
            n_valid_after !== 0) begin
            errors++;
            $display("FAIL start_in_gen: got xfer=%0d err=%0d done=%0d expected 4 0 1",
                     n_xfer, n_err, n_done);
        end
    endtask

    task automatic test_reset_mid;
        logic [11:0] o;
        dim_m = 3'd3; dim_n = 3'd3; count = 4'd2;
        elem_min = 8'd1; elem_max = 8'd200; signed_mode = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        o = {out_valid, busy, done, err, out_data};
        checks++;
        if (o !== 12'h0) begin
            errors++;
            $display("FAIL reset_mid: got %h expected 0", o);
        end
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_const_and_full();
        test_signed();
        try_reject("signed_bounds_unsigned", 3, 3, 1, 8'hFD, 8'h03, 1'b0);
        try_reject("dim_m0", 0, 3, 1, 8'd0, 8'd9, 1'b0);
        try_reject("dim_n0", 2, 0, 1, 8'd0, 8'd9, 1'b0);
        try_reject("count0", 2, 2, 0, 8'd0, 8'd9, 1'b0);
        test_backpressure();
        test_abort();
        test_start_in_gen();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
